// File: rtl/spi_master_xfer.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_xfer
// Brief   : Full-duplex SPI master with generated SCLK, CPOL/CPHA modes,
//           configurable word width/bit order and an RX holding register.
// Revision: 1.0 - initial release
// ============================================================================
module spi_master_xfer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  WRITE,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic [DIV_WIDTH-1:0]  DIVISOR,
  input  logic                  READ,
  input  logic                  MISO,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  SS_N,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  BUSY,
  output logic                  RX_FULL,
  output logic                  OVERRUN
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam int                  c_edge_w     = $clog2(2*DATA_WIDTH+2);
  localparam logic [c_edge_w-1:0] c_first_edge = c_edge_w'(1);
  localparam logic [c_edge_w-1:0] c_last_edge  = c_edge_w'(2*DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_next;

  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [DATA_WIDTH-1:0] w_tx_shifted;
  logic [DATA_WIDTH-1:0] w_rx_shifted;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_hcnt;
  logic [c_edge_w-1:0]   r_ecnt;
  logic [c_edge_w-1:0]   w_edge_num;

  logic r_cpha;
  logic r_sclk;
  logic r_rx_full;
  logic r_overrun;
  logic w_tx_bit;
  logic w_start;
  logic w_done;
  logic w_tick;
  logic w_edge;
  logic w_shift_tx;
  logic w_sample;

  // --------------------------------------------------------------------------
  // Bit-order dependent shift paths
  // --------------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_tx_bit     = r_tx[DATA_WIDTH-1];
      assign w_tx_shifted = {r_tx[DATA_WIDTH-2:0], 1'b0};
      assign w_rx_shifted = {r_rx[DATA_WIDTH-2:0], MISO};
    end else begin : g_lsb_first
      assign w_tx_bit     = r_tx[0];
      assign w_tx_shifted = {1'b0, r_tx[DATA_WIDTH-1:1]};
      assign w_rx_shifted = {MISO, r_rx[DATA_WIDTH-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Edge timing: one tick every H = DIVISOR+1 cycles after the start edge
  // --------------------------------------------------------------------------
  assign w_tick     = (r_state != S_IDLE) && (r_hcnt == r_div);
  assign w_edge     = w_tick && ((r_state == S_SETUP) || (r_state == S_XFER));
  assign w_edge_num = r_ecnt + c_first_edge;

  // MOSI advances on edges of parity CPHA, never on edge 1 or the final edge
  assign w_shift_tx = (w_edge_num[0] == r_cpha) &&
                      (w_edge_num > c_first_edge) &&
                      (w_edge_num < c_last_edge);
  assign w_sample   = (w_edge_num[0] != r_cpha);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (WRITE) begin
          w_start      = 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tick) begin
          w_state_next = S_XFER;
        end
      end
      S_XFER: begin
        if (w_tick && (w_edge_num == c_last_edge)) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift engine and shadow registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_cpha <= 1'b0;
      r_div  <= '0;
      r_sclk <= 1'b0;
      r_hcnt <= '0;
      r_ecnt <= '0;
    end else if (w_start) begin
      r_tx   <= TX_DATA;
      r_rx   <= '0;
      r_cpha <= CPHA;
      r_div  <= DIVISOR;
      r_sclk <= CPOL;
      r_hcnt <= '0;
      r_ecnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_hcnt <= w_tick ? '0 : r_hcnt + 1'b1;
      if (w_edge) begin
        r_ecnt <= w_edge_num;
        r_sclk <= ~r_sclk;
        if (w_shift_tx) begin
          r_tx <= w_tx_shifted;
        end
        if (w_sample) begin
          r_rx <= w_rx_shifted;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Receive holding register; a simultaneous READ frees the slot for the new word
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_rx_data <= '0;
      r_rx_full <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      r_rx_data <= r_rx;
      r_rx_full <= 1'b1;
      if (r_rx_full && !READ) begin
        r_overrun <= 1'b1;
      end
    end else if (READ) begin
      r_rx_full <= 1'b0;
    end
  end

  assign SCLK    = r_sclk;
  assign MOSI    = (r_state != S_IDLE) && w_tx_bit;
  assign SS_N    = (r_state == S_IDLE);
  assign BUSY    = (r_state != S_IDLE);
  assign RX_DATA = r_rx_data;
  assign RX_FULL = r_rx_full;
  assign OVERRUN = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_xfer.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master_xfer
// Brief   : Scoreboard bench for spi_master_xfer (8-bit MSB and 12-bit LSB)
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_master_xfer;

  typedef struct {
    logic [31:0] rx;
    logic [31:0] mosi;
    int          busy;
    int          edges;
    bit          ovr;
    bit          cpol;
    bit          cpha;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  // Instance A: 8-bit, MSB first
  logic [7:0]  tx_a, rxd_a, div_a;
  logic        write_a, cpol_a, cpha_a, read_a, miso_a;
  logic        sclk_a, mosi_a, ssn_a, busy_a, full_a, ovr_a;
  // Instance B: 12-bit, LSB first
  logic [11:0] tx_b, rxd_b;
  logic [7:0]  div_b;
  logic        write_b, cpol_b, cpha_b, read_b, miso_b;
  logic        sclk_b, mosi_b, ssn_b, busy_b, full_b, ovr_b;

  logic        slave_en;
  logic        slave_bit;
  logic [7:0]  slave_word;

  assign miso_a = slave_en ? slave_bit : mosi_a;
  assign miso_b = mosi_b;

  spi_master_xfer #(.DATA_WIDTH(8), .DIV_WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
    .CLK(clk), .CLR(clr), .TX_DATA(tx_a), .WRITE(write_a), .CPOL(cpol_a),
    .CPHA(cpha_a), .DIVISOR(div_a), .READ(read_a), .MISO(miso_a),
    .SCLK(sclk_a), .MOSI(mosi_a), .SS_N(ssn_a), .RX_DATA(rxd_a),
    .BUSY(busy_a), .RX_FULL(full_a), .OVERRUN(ovr_a)
  );

  spi_master_xfer #(.DATA_WIDTH(12), .DIV_WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
    .CLK(clk), .CLR(clr), .TX_DATA(tx_b), .WRITE(write_b), .CPOL(cpol_b),
    .CPHA(cpha_b), .DIVISOR(div_b), .READ(read_b), .MISO(miso_b),
    .SCLK(sclk_b), .MOSI(mosi_b), .SS_N(ssn_b), .RX_DATA(rxd_b),
    .BUSY(busy_b), .RX_FULL(full_b), .OVERRUN(ovr_b)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // CLR as seen by the design at the most recent posedge
  logic clr_q = 1'b0;
  always @(posedge clk) clr_q <= clr;

  // Slave model: shifts slave_word out MSB first on leading (odd) SCLK edges
  int   s_cnt = 0;
  logic s_ss_prev = 1'b1;
  logic s_sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (ssn_a) begin
      s_cnt = 0;
    end else if (!s_ss_prev && (sclk_a != s_sclk_prev)) begin
      s_cnt++;
      if (s_cnt % 2 == 1) slave_bit = slave_word[7 - (s_cnt - 1) / 2];
    end
    s_ss_prev   = ssn_a;
    s_sclk_prev = sclk_a;
  end

  // Monitor A
  int          a_bc = 0, a_ec = 0;
  logic [31:0] a_cap = '0;
  logic        a_busy_prev = 1'b0, a_sclk_prev = 1'b0;
  exp_t        ea;
  always @(negedge clk) begin
    if (clr_q) begin
      a_bc = 0; a_ec = 0; a_cap = '0;
    end else begin
      if (busy_a) begin
        a_bc++;
        if (a_busy_prev && (sclk_a != a_sclk_prev)) begin
          a_ec++;
          if (qa.size() > 0 && (((a_ec % 2) == 1) != qa[0].cpha))
            a_cap = {a_cap[30:0], mosi_a};
        end
      end
      if (a_busy_prev && !busy_a) begin
        if (qa.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL a_unexpected_done: got completion expected none");
        end else begin
          ea = qa.pop_front();
          chk("a_rx_data", 32'(rxd_a), ea.rx);
          chk("a_mosi_bits", a_cap, ea.mosi);
          chk("a_busy_cycles", 32'(a_bc), 32'(ea.busy));
          chk("a_sclk_edges", 32'(a_ec), 32'(ea.edges));
          chk("a_rx_full", 32'(full_a), 32'd1);
          chk("a_overrun", 32'(ovr_a), 32'(ea.ovr));
          chk("a_ss_n_done", 32'(ssn_a), 32'd1);
          chk("a_sclk_idle", 32'(sclk_a), 32'(ea.cpol));
        end
        a_bc = 0; a_ec = 0; a_cap = '0;
      end
    end
    a_busy_prev = busy_a;
    a_sclk_prev = sclk_a;
  end

  // Monitor B
  int          b_bc = 0, b_ec = 0;
  logic [31:0] b_cap = '0;
  logic        b_busy_prev = 1'b0, b_sclk_prev = 1'b0;
  exp_t        eb;
  always @(negedge clk) begin
    if (clr_q) begin
      b_bc = 0; b_ec = 0; b_cap = '0;
    end else begin
      if (busy_b) begin
        b_bc++;
        if (b_busy_prev && (sclk_b != b_sclk_prev)) begin
          b_ec++;
          if (qb.size() > 0 && (((b_ec % 2) == 1) != qb[0].cpha))
            b_cap = {b_cap[30:0], mosi_b};
        end
      end
      if (b_busy_prev && !busy_b) begin
        if (qb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL b_unexpected_done: got completion expected none");
        end else begin
          eb = qb.pop_front();
          chk("b_rx_data", 32'(rxd_b), eb.rx);
          chk("b_mosi_bits", b_cap, eb.mosi);
          chk("b_busy_cycles", 32'(b_bc), 32'(eb.busy));
          chk("b_sclk_edges", 32'(b_ec), 32'(eb.edges));
          chk("b_rx_full", 32'(full_b), 32'd1);
          chk("b_overrun", 32'(ovr_b), 32'(eb.ovr));
        end
        b_bc = 0; b_ec = 0; b_cap = '0;
      end
    end
    b_busy_prev = busy_b;
    b_sclk_prev = sclk_b;
  end

  task automatic push_a(input logic [31:0] rx, input logic [31:0] mo, input int busy,
                        input bit ovr, input bit cpol, input bit cpha);
    exp_t e;
    e.rx = rx; e.mosi = mo; e.busy = busy; e.edges = 16;
    e.ovr = ovr; e.cpol = cpol; e.cpha = cpha;
    qa.push_back(e);
  endtask

  task automatic start_a(input logic [7:0] d, input bit pol, input bit pha, input logic [7:0] dv);
    @(negedge clk);
    tx_a = d; cpol_a = pol; cpha_a = pha; div_a = dv; write_a = 1'b1;
    @(negedge clk);
    write_a = 1'b0;
  endtask

  task automatic wait_idle(input bit use_b);
    int n;
    n = 0;
    while ((use_b ? busy_b : busy_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (use_b ? busy_b : busy_a) begin
      n_checks++; n_err++;
      $display("FAIL wait_idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic read_a_pulse();
    @(negedge clk); read_a = 1'b1;
    @(negedge clk); read_a = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    clr = 1'b1;
    tx_a = '0; write_a = 0; cpol_a = 0; cpha_a = 0; div_a = '0; read_a = 0;
    tx_b = '0; write_b = 0; cpol_b = 0; cpha_b = 0; div_b = '0; read_b = 0;
    slave_en = 1'b0; slave_bit = 1'b0; slave_word = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ss_n", 32'(ssn_a), 32'd1);
    chk("rst_sclk", 32'(sclk_a), 32'd0);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_rx_full", 32'(full_a), 32'd0);
    chk("rst_overrun", 32'(ovr_a), 32'd0);
    chk("rst_rx_data", 32'(rxd_a), 32'd0);

    // Mode 0, H=2, loopback 0xA5: 34 busy cycles
    push_a(32'hA5, 32'hA5, 34, 1'b0, 1'b0, 1'b0);
    start_a(8'hA5, 1'b0, 1'b0, 8'd1);
    wait_idle(1'b0);
    read_a_pulse();

    // Mode 3, H=1, slave returns 0x3C: 17 busy cycles, SCLK idles high
    slave_word = 8'h3C; slave_en = 1'b1;
    push_a(32'h3C, 32'h96, 17, 1'b0, 1'b1, 1'b1);
    start_a(8'h96, 1'b1, 1'b1, 8'd0);
    wait_idle(1'b0);
    @(negedge clk);
    chk("mode3_sclk_idle_high", 32'(sclk_a), 32'd1);
    slave_en = 1'b0;
    read_a_pulse();

    // Back-to-back without READ -> overrun
    push_a(32'h11, 32'h11, 17, 1'b0, 1'b0, 1'b0);
    start_a(8'h11, 1'b0, 1'b0, 8'd0);
    wait_idle(1'b0);
    push_a(32'h22, 32'h22, 17, 1'b1, 1'b0, 1'b0);
    start_a(8'h22, 1'b0, 1'b0, 8'd0);
    wait_idle(1'b0);
    read_a_pulse();
    chk("read_clears_full", 32'(full_a), 32'd0);
    chk("overrun_sticky", 32'(ovr_a), 32'd1);
    chk("read_keeps_rx_data", 32'(rxd_a), 32'h22);
    clr_pulse();
    chk("clr_clears_overrun", 32'(ovr_a), 32'd0);

    // Repeat with READ on the completion edge -> no overrun
    push_a(32'h11, 32'h11, 17, 1'b0, 1'b0, 1'b0);
    start_a(8'h11, 1'b0, 1'b0, 8'd0);
    wait_idle(1'b0);
    push_a(32'h22, 32'h22, 17, 1'b0, 1'b0, 1'b0);
    start_a(8'h22, 1'b0, 1'b0, 8'd0);
    repeat (16) @(negedge clk);
    read_a = 1'b1;
    @(negedge clk);
    read_a = 1'b0;
    wait_idle(1'b0);
    read_a_pulse();

    // WRITE during BUSY is ignored
    push_a(32'h0F, 32'h0F, 34, 1'b0, 1'b0, 1'b0);
    start_a(8'h0F, 1'b0, 1'b0, 8'd1);
    repeat (4) @(negedge clk);
    tx_a = 8'hFF; write_a = 1'b1;
    @(negedge clk);
    write_a = 1'b0;
    wait_idle(1'b0);

    // CLR at T0+9 aborts; RX_FULL was left set by the previous word
    start_a(8'h5A, 1'b0, 1'b0, 8'd1);
    repeat (8) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_ss_n", 32'(ssn_a), 32'd1);
    chk("abort_sclk", 32'(sclk_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_rx_full", 32'(full_a), 32'd0);
    chk("abort_rx_data", 32'(rxd_a), 32'd0);
    chk("abort_mosi", 32'(mosi_a), 32'd0);

    // Fresh transfer after abort: mode 1, H=3 -> 51 busy cycles
    push_a(32'hC3, 32'hC3, 51, 1'b0, 1'b0, 1'b1);
    start_a(8'hC3, 1'b0, 1'b1, 8'd2);
    wait_idle(1'b0);
    read_a_pulse();

    // 12-bit LSB-first loopback 0x5A3: bits on the wire reversed = 0xC5A
    e.rx = 32'h5A3; e.mosi = 32'hC5A; e.busy = 25; e.edges = 24;
    e.ovr = 1'b0; e.cpol = 1'b0; e.cpha = 1'b0;
    qb.push_back(e);
    @(negedge clk);
    tx_b = 12'h5A3; cpol_b = 1'b0; cpha_b = 1'b0; div_b = 8'd0; write_b = 1'b1;
    @(negedge clk);
    write_b = 1'b0;
    wait_idle(1'b1);
    repeat (2) @(negedge clk);

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
